hu_fwd_stall_ctrl: RTL and testbench

//  Parametrised hazard unit for the E stage: forwards operands from NUM_SRC younger producers (M, W, late-W, buffer...).

---
 rtl/hu_fwd_stall_ctrl_pkg.sv | 6 +
 rtl/hu_operand_sel.sv | 48 ++++
 rtl/hu_fwd_stall_ctrl.sv | 68 ++++++
 tb/tb_hu_fwd_stall_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hu_fwd_stall_ctrl_pkg.sv
// hu_fwd_stall_ctrl_pkg: shared register-index width, x0 constant and hazard FSM states
package hu_fwd_stall_ctrl_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0 = '0;
  typedef enum logic {RUN, WAIT} hu_state_t;
endpackage

// File: rtl/hu_operand_sel.sv
// hu_operand_sel: per-operand youngest-first forwarding match with a stall-time hold register
module hu_operand_sel
  import hu_fwd_stall_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REG_IDX_W-1:0]         rs,
  input  logic                         ren,
  input  logic [XLEN-1:0]              rf_rdata,
  input  logic [NUM_SRC-1:0]           src_we,
  input  logic [NUM_SRC*REG_IDX_W-1:0] src_rd,
  input  logic [NUM_SRC-1:0]           src_rdy,
  input  logic [NUM_SRC*XLEN-1:0]      src_data,
  input  logic                         stall,
  output logic [XLEN-1:0]              opnd,
  output logic                         hazard
);
  logic            hold_vld;
  logic [XLEN-1:0] hold;
  logic [XLEN-1:0] fwd;
  logic            pend;
  // scan oldest to youngest so the youngest match is applied last, readiness included
  always_comb begin
    fwd  = rf_rdata;
    pend = 1'b0;
    for (int j = NUM_SRC - 1; j >= 0; j--)
      if (src_we[j] && src_rd[j*REG_IDX_W +: REG_IDX_W] == rs) begin
        fwd  = src_data[j*XLEN +: XLEN];
        pend = ~src_rdy[j];
      end
  end
  assign opnd   = (!ren || rs == X0) ? '0 : hold_vld ? hold : fwd;
  assign hazard = ren && rs != X0 && !hold_vld && pend;
  // latch a resolved operand while E is stalled; any non-stalled edge releases it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold     <= '0;
    end else if (!stall) begin
      hold_vld <= 1'b0;
    end else if (ren && !hold_vld && !hazard) begin
      hold_vld <= 1'b1;
      hold     <= opnd;
    end
endmodule

// File: rtl/hu_fwd_stall_ctrl.sv
// hu_fwd_stall_ctrl: E-stage forwarding, use-before-ready stall, stall timeout and stall statistics
module hu_fwd_stall_ctrl
  import hu_fwd_stall_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 4,
  parameter int NUM_RS     = 2,
  parameter int TMO_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_E,
  input  logic                         valid_E,
  input  logic [NUM_RS*REG_IDX_W-1:0]  rs_E,
  input  logic [NUM_RS-1:0]            ren_E,
  input  logic [NUM_RS*XLEN-1:0]       rf_rdata_E,
  input  logic [NUM_SRC-1:0]           src_we,
  input  logic [NUM_SRC*REG_IDX_W-1:0] src_rd,
  input  logic [NUM_SRC-1:0]           src_rdy,
  input  logic [NUM_SRC*XLEN-1:0]      src_data,
  output logic [NUM_RS*XLEN-1:0]       opnd_E,
  output logic                         stall_E,
  output logic                         stall_tmo,
  output logic [31:0]                  stall_cycles
);
  localparam logic [15:0] TMO = TMO_CYCLES[15:0];
  hu_state_t         state_q, state_d;
  logic [NUM_RS-1:0] hazard;
  logic [15:0]       stall_cnt, cnt_d;
  genvar i;
  generate
    for (i = 0; i < NUM_RS; i++) begin : g_op
      hu_operand_sel #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) u_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs       (rs_E[i*REG_IDX_W +: REG_IDX_W]),
        .ren      (ren_E[i]),
        .rf_rdata (rf_rdata_E[i*XLEN +: XLEN]),
        .src_we   (src_we),
        .src_rd   (src_rd),
        .src_rdy  (src_rdy),
        .src_data (src_data),
        .stall    (stall_E),
        .opnd     (opnd_E[i*XLEN +: XLEN]),
        .hazard   (hazard[i])
      );
    end
  endgenerate
  assign stall_E = valid_E && !flush_E && |hazard;
  // flush, advance and idle all drop stall_E, so they all return to RUN and zero the run length
  always_comb begin
    state_d = stall_E ? WAIT : RUN;
    cnt_d   = !stall_E ? '0 : state_q == RUN ? 16'd1 : &stall_cnt ? stall_cnt : stall_cnt + 16'd1;
  end
  // FSM, consecutive-stall counter, sticky timeout and saturating total
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= RUN;
      stall_cnt    <= '0;
      stall_tmo    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q      <= state_d;
      stall_cnt    <= cnt_d;
      stall_tmo    <= stall_tmo | (cnt_d == TMO);
      stall_cycles <= stall_cycles + {31'd0, stall_E && !(&stall_cycles)};
    end
endmodule

// File: tb/tb_hu_fwd_stall_ctrl.sv
// tb_hu_fwd_stall_ctrl: directed and random stimulus against a queue-based reference model
module tb_hu_fwd_stall_ctrl;
  localparam int XLEN = 32;
  localparam int NUM_SRC = 4;
  localparam int NUM_RS = 2;
  localparam int TMO = 4;

  logic clk = 0, rst_n = 0, flush_E = 0, valid_E = 0;
  logic [NUM_RS*5-1:0]     rs_E = '0;
  logic [NUM_RS-1:0]       ren_E = '0;
  logic [NUM_RS*XLEN-1:0]  rf_rdata_E = '0;
  logic [NUM_SRC-1:0]      src_we = '0, src_rdy = '0;
  logic [NUM_SRC*5-1:0]    src_rd = '0;
  logic [NUM_SRC*XLEN-1:0] src_data = '0;
  logic [NUM_RS*XLEN-1:0]  opnd_E;
  logic                    stall_E, stall_tmo;
  logic [31:0]             stall_cycles;

  hu_fwd_stall_ctrl #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_RS(NUM_RS), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .flush_E(flush_E), .valid_E(valid_E), .rs_E(rs_E), .ren_E(ren_E),
    .rf_rdata_E(rf_rdata_E), .src_we(src_we), .src_rd(src_rd), .src_rdy(src_rdy), .src_data(src_data),
    .opnd_E(opnd_E), .stall_E(stall_E), .stall_tmo(stall_tmo), .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_RS*XLEN-1:0] op;
    logic [NUM_RS-1:0]      chk;
    logic                   st;
    logic                   tmo;
    logic [31:0]            cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;

  logic            m_hv[NUM_RS];
  logic [XLEN-1:0] m_hold[NUM_RS];
  int              m_cnt;
  logic            m_tmo, m_last_st;
  longint unsigned m_total;

  function automatic int find_src(input logic [4:0] r);
    for (int j = 0; j < NUM_SRC; j++)
      if (src_we[j] && src_rd[j*5 +: 5] == r) return j;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_RS; i++) begin
      m_hv[i] = 0;
      m_hold[i] = '0;
    end
    m_cnt = 0;
    m_tmo = 0;
    m_total = 0;
  endtask

  task automatic cycle();
    exp_t x;
    logic [XLEN-1:0] op[NUM_RS];
    logic [NUM_RS-1:0] hz;
    logic [4:0] r;
    int j;
    for (int i = 0; i < NUM_RS; i++) begin
      r = rs_E[i*5 +: 5];
      j = find_src(r);
      hz[i] = 0;
      if (!ren_E[i] || r == 0) op[i] = '0;
      else if (m_hv[i]) op[i] = m_hold[i];
      else if (j < 0) op[i] = rf_rdata_E[i*XLEN +: XLEN];
      else if (src_rdy[j]) op[i] = src_data[j*XLEN +: XLEN];
      else begin
        hz[i] = 1;
        op[i] = '0;
      end
      x.op[i*XLEN +: XLEN] = op[i];
    end
    x.chk = ~hz;
    x.st = valid_E && !flush_E && (hz != 0);
    x.tmo = m_tmo;
    x.cyc = (m_total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_total[31:0];
    q.push_back(x);
    m_last_st = x.st;
    if (rst_n) begin
      if (!x.st) begin
        for (int i = 0; i < NUM_RS; i++) m_hv[i] = 0;
        m_cnt = 0;
      end else begin
        for (int i = 0; i < NUM_RS; i++)
          if (ren_E[i] && !m_hv[i] && !hz[i]) begin
            m_hv[i] = 1;
            m_hold[i] = op[i];
          end
        m_cnt++;
        m_total++;
        if (m_cnt == TMO) m_tmo = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_clear();
    cycle();
    rst_n = 1;
  endtask

  task automatic set_src(input int j, input logic we, input logic [4:0] rd, input logic rdy, input logic [XLEN-1:0] d);
    src_we[j] = we;
    src_rd[j*5 +: 5] = rd;
    src_rdy[j] = rdy;
    src_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_op(input int i, input logic en, input logic [4:0] r, input logic [XLEN-1:0] rf);
    ren_E[i] = en;
    rs_E[i*5 +: 5] = r;
    rf_rdata_E[i*XLEN +: XLEN] = rf;
  endtask

  task automatic clr_src();
    src_we = '0;
    src_rdy = '0;
    src_rd = '0;
    src_data = '0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      check("stall_E", {31'd0, stall_E}, {31'd0, e.st});
      check("stall_tmo", {31'd0, stall_tmo}, {31'd0, e.tmo});
      check("stall_cycles", stall_cycles, e.cyc);
      for (int i = 0; i < NUM_RS; i++)
        if (e.chk[i]) check($sformatf("opnd%0d", i), opnd_E[i*XLEN +: XLEN], e.op[i*XLEN +: XLEN]);
    end

  initial begin
    logic new_instr;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    valid_E = 1;
    set_op(0, 1, 5, 32'hAAAA);
    set_op(1, 0, 0, 32'h0);
    set_src(0, 1, 5, 1, 32'h11);
    set_src(1, 1, 5, 1, 32'h22);
    cycle();
    clr_src();
    set_op(0, 0, 0, 0);
    set_op(1, 1, 7, 32'hBEEF);
    set_src(0, 1, 7, 0, 32'h0);
    repeat (3) cycle();
    set_src(0, 1, 7, 1, 32'hABCD);
    cycle();
    clr_src();
    valid_E = 0;
    cycle();
    valid_E = 1;
    set_op(0, 1, 3, 32'h3333);
    set_op(1, 1, 7, 32'h7777);
    set_src(1, 1, 3, 1, 32'h55);
    set_src(0, 1, 7, 0, 32'h0);
    cycle();
    set_src(1, 0, 0, 0, 32'h0);
    cycle();
    set_src(0, 1, 7, 1, 32'h9999);
    cycle();
    clr_src();
    cycle();
    set_op(0, 1, 0, 32'h1234);
    set_op(1, 0, 7, 32'h5678);
    set_src(0, 1, 0, 0, 32'h1);
    set_src(1, 1, 7, 0, 32'h2);
    cycle();
    clr_src();
    set_op(0, 1, 9, 32'h9);
    set_op(1, 0, 0, 32'h0);
    set_src(0, 1, 9, 0, 32'h0);
    repeat (5) cycle();
    flush_E = 1;
    cycle();
    flush_E = 0;
    clr_src();
    cycle();
    set_op(0, 1, 4, 32'h1234);
    set_op(1, 1, 6, 32'h6666);
    set_src(2, 1, 6, 0, 32'h0);
    repeat (2) cycle();
    set_op(0, 1, 4, 32'h4321);
    do_reset();
    cycle();
    new_instr = 1;
    for (int n = 0; n < 400; n++) begin
      if (new_instr)
        for (int i = 0; i < NUM_RS; i++)
          set_op(i, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      valid_E = $urandom_range(0, 7) != 0;
      flush_E = $urandom_range(0, 15) == 0;
      for (int j = 0; j < NUM_SRC; j++)
        set_src(j, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, $urandom);
      cycle();
      new_instr = !m_last_st;
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
